// File: rtl/traffic_request_ctrl_if.sv
// rtl/traffic_request_ctrl_if.sv - button/sensor/lamp inputs and request outputs of traffic_request_ctrl
interface traffic_request_ctrl_if;
  logic       btn;
  logic       sensor;
  logic       R;
  logic       Y;
  logic       G;
  logic       start;
  logic       req_pending;
  logic       fault;
  logic [1:0] state_o;

  modport master (
    output btn, sensor, R, Y, G,
    input  start, req_pending, fault, state_o
  );

  modport slave (
    input  btn, sensor, R, Y, G,
    output start, req_pending, fault, state_o
  );
endinterface

// File: rtl/traffic_request_ctrl.sv
// rtl/traffic_request_ctrl.sv - debounced request stage driving start to the traffic-light FSM
// Optional periodic self-request when built with AUTO_CYCLE_EN.
module traffic_request_ctrl #(
  parameter int DEBOUNCE    = 4,
  parameter int MIN_RED     = 8,
  parameter int CNT_W       = 8,
  parameter int AUTO_PERIOD = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  traffic_request_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    HOLD  = 2'b01,
    ISSUE = 2'b10,
    SERVE = 2'b11
  } state_t;

  state_t           state_q;
  logic             start_q;
  logic             req_pending_q;
  logic             fault_q;

  // Bit 0 carries btn, bit 1 carries sensor through identical conditioning.
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       lvl_q, lvl_d, lvl_prev_q;
  logic [CNT_W-1:0] db_cnt_q [2];
  logic [CNT_W-1:0] db_cnt_d [2];
  logic [CNT_W-1:0] red_cnt_q, red_cnt_d;

  logic             req_evt;
  logic             lamp_bad;
  logic             force_idle;
  logic             auto_fire;
  logic             pend_set;
  logic             pend_clr;

  always_comb begin
    lvl_d = lvl_q;
    for (int i = 0; i < 2; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != lvl_q[i]) begin
        if (db_cnt_q[i] == CNT_W'(DEBOUNCE - 1)) begin
          lvl_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    red_cnt_d = red_cnt_q;
    if (!bus.R) begin
      red_cnt_d = '0;
    end else if (red_cnt_q != CNT_W'(MIN_RED)) begin
      red_cnt_d = red_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      lvl_q       <= '0;
      lvl_prev_q  <= '0;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
      red_cnt_q   <= '0;
    end else begin
      sync1_q     <= {bus.sensor, bus.btn};
      sync2_q     <= sync1_q;
      lvl_q       <= lvl_d;
      lvl_prev_q  <= lvl_q;
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
      red_cnt_q   <= red_cnt_d;
    end
  end

  // Coincident rising edges on both channels collapse into one event.
  assign req_evt    = |(lvl_q & ~lvl_prev_q);
  assign lamp_bad   = !((bus.R ^ bus.Y ^ bus.G) && !(bus.R && bus.Y && bus.G));
  assign force_idle = lamp_bad || fault_q;
  assign pend_set   = (req_evt && (state_q != ISSUE)) || auto_fire;
  assign pend_clr   = (state_q == ISSUE) && bus.G && !force_idle;

`ifdef AUTO_CYCLE_EN
  logic [CNT_W-1:0] auto_cnt_q;
  logic             auto_run;

  assign auto_run  = (state_q == IDLE) && bus.R && !req_pending_q && !req_evt;
  assign auto_fire = auto_run && (auto_cnt_q == CNT_W'(AUTO_PERIOD - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      auto_cnt_q <= '0;
    end else if (!auto_run || auto_fire) begin
      auto_cnt_q <= '0;
    end else begin
      auto_cnt_q <= auto_cnt_q + 1'b1;
    end
  end
`else
  assign auto_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      start_q       <= 1'b0;
      req_pending_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      if (lamp_bad) begin
        fault_q <= 1'b1;
      end
      if (pend_clr) begin
        req_pending_q <= 1'b0;
      end else if (pend_set) begin
        req_pending_q <= 1'b1;
      end
      // A bad lamp vector parks the FSM in the same edge that latches fault.
      if (force_idle) begin
        state_q <= IDLE;
        start_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (req_pending_q && bus.R) begin
              state_q <= HOLD;
            end
          end
          HOLD: begin
            if (!bus.R) begin
              state_q <= IDLE;
            end else if (red_cnt_q == CNT_W'(MIN_RED)) begin
              state_q <= ISSUE;
              start_q <= 1'b1;
            end
          end
          ISSUE: begin
            if (bus.G) begin
              state_q <= SERVE;
              start_q <= 1'b0;
            end
          end
          SERVE: begin
            if (bus.R) begin
              state_q <= IDLE;
            end
          end
          default: begin
            state_q <= IDLE;
            start_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.start       = start_q;
  assign bus.req_pending = req_pending_q;
  assign bus.fault       = fault_q;
  assign bus.state_o     = state_q;

endmodule

// File: tb/tb_traffic_request_ctrl.sv
// tb/tb_traffic_request_ctrl.sv - randomized self-checking bench for traffic_request_ctrl
module tb_traffic_request_ctrl;
  localparam int DB = 4;
  localparam int MR = 8;
  localparam int AP = 64;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  traffic_request_ctrl_if bus ();

  traffic_request_ctrl #(
    .DEBOUNCE   (DB),
    .MIN_RED    (MR),
    .CNT_W      (8),
    .AUTO_PERIOD(AP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Expected outputs packed as {start, req_pending, fault, state}.
  function automatic logic [4:0] ev(input logic s, input logic p, input logic f, input logic [1:0] st);
    return {s, p, f, st};
  endfunction

  function automatic logic [4:0] obs();
    return {bus.start, bus.req_pending, bus.fault, bus.state_o};
  endfunction

  // Edge (counted from the first sampling edge) at which a press of len cycles raises req_pending.
  function automatic int pend_edge(input int len);
    return (len >= DB) ? DB + 3 : -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lamps(input logic r, input logic y, input logic g);
    bus.R = r;
    bus.Y = y;
    bus.G = g;
  endtask

  task automatic park();
    set_lamps(1'b0, 1'b0, 1'b1);
    bus.btn    = 1'b0;
    bus.sensor = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset();
    bus.btn    = 1'b1;
    bus.sensor = 1'b0;
    set_lamps(1'b1, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if (obs() !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_async got=%b exp=%b", obs(), 5'b0);
    end
    for (int k = 1; k <= 20; k++) begin
      step();
      n_tests++;
      if (obs() !== 5'b0) begin
        n_fail++;
        $display("FAIL reset_hold k=%0d got=%b exp=%b", k, obs(), 5'b0);
      end
    end
    bus.btn = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_glitch();
    int len;
    for (int t = 0; t < 3; t++) begin
      len = (t == 0) ? 2 : int'($urandom_range(1, DB - 1));
      set_lamps(1'b1, 1'b0, 1'b0);
      bus.btn = 1'b1;
      for (int k = 1; k <= 30; k++) begin
        step();
        if (k == len) bus.btn = 1'b0;
        n_tests++;
        if (obs() !== ev(1'b0, (pend_edge(len) >= 0 && k >= pend_edge(len)), 1'b0, 2'b00)) begin
          n_fail++;
          $display("FAIL glitch len=%0d k=%0d got=%b exp=%b", len, k, obs(), 5'b0);
        end
      end
      park();
    end
  endtask

  task automatic test_nominal();
    int pre, hold, last, pe;
    logic [4:0] exp;
    pre  = $urandom_range(8, 16);
    hold = $urandom_range(DB + 1, 20);
    last = DB + 5 + $urandom_range(0, 20);
    pe   = pend_edge(hold);
    set_lamps(1'b1, 1'b0, 1'b0);
    repeat (pre) step();
    bus.btn = 1'b1;
    for (int k = 1; k <= last; k++) begin
      step();
      if (k == hold) bus.btn = 1'b0;
      if (k < pe)           exp = ev(1'b0, 1'b0, 1'b0, 2'b00);
      else if (k == pe)     exp = ev(1'b0, 1'b1, 1'b0, 2'b00);
      else if (k == pe + 1) exp = ev(1'b0, 1'b1, 1'b0, 2'b01);
      else                  exp = ev(1'b1, 1'b1, 1'b0, 2'b10);
      n_tests++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL nominal k=%0d hold=%0d got=%b exp=%b", k, hold, obs(), exp);
      end
    end
    bus.btn = 1'b0;
    set_lamps(1'b0, 1'b0, 1'b1);
    step();
    n_tests++;
    if (obs() !== ev(1'b0, 1'b0, 1'b0, 2'b11)) begin
      n_fail++;
      $display("FAIL nominal_green got=%b exp=%b", obs(), ev(1'b0, 1'b0, 1'b0, 2'b11));
    end
    set_lamps(1'b0, 1'b1, 1'b0);
    step();
    n_tests++;
    if (obs() !== ev(1'b0, 1'b0, 1'b0, 2'b11)) begin
      n_fail++;
      $display("FAIL nominal_yellow got=%b exp=%b", obs(), ev(1'b0, 1'b0, 1'b0, 2'b11));
    end
    set_lamps(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      step();
      n_tests++;
      if (obs() !== 5'b0) begin
        n_fail++;
        $display("FAIL nominal_no_repeat k=%0d got=%b exp=%b", k, obs(), 5'b0);
      end
    end
    park();
  endtask

  task automatic test_latched_green();
    int len, pe;
    logic [4:0] exp;
    len = $urandom_range(DB, 12);
    pe  = pend_edge(len);
    set_lamps(1'b0, 1'b0, 1'b1);
    bus.sensor = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == len) bus.sensor = 1'b0;
      exp = ev(1'b0, (k >= pe), 1'b0, 2'b00);
      n_tests++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL latched_green k=%0d got=%b exp=%b", k, obs(), exp);
      end
    end
    set_lamps(1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      step();
      n_tests++;
      if (obs() !== ev(1'b0, 1'b1, 1'b0, 2'b00)) begin
        n_fail++;
        $display("FAIL latched_yellow k=%0d got=%b exp=%b", k, obs(), ev(1'b0, 1'b1, 1'b0, 2'b00));
      end
    end
    set_lamps(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= MR + 1; k++) begin
      step();
      exp = (k == MR + 1) ? ev(1'b1, 1'b1, 1'b0, 2'b10) : ev(1'b0, 1'b1, 1'b0, 2'b01);
      n_tests++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL latched_red k=%0d got=%b exp=%b", k, obs(), exp);
      end
    end
    set_lamps(1'b0, 1'b0, 1'b1);
    step();
    set_lamps(1'b1, 1'b0, 1'b0);
    step();
    n_tests++;
    if (obs() !== 5'b0) begin
      n_fail++;
      $display("FAIL latched_return got=%b exp=%b", obs(), 5'b0);
    end
    park();
  endtask

  task automatic test_fault();
    int n;
    n = $urandom_range(1, MR - 2);
    set_lamps(1'b0, 1'b0, 1'b1);
    bus.btn = 1'b1;
    repeat (DB + 1) step();
    bus.btn = 1'b0;
    repeat (4) step();
    set_lamps(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= n; k++) begin
      step();
      n_tests++;
      if (obs() !== ev(1'b0, 1'b1, 1'b0, 2'b01)) begin
        n_fail++;
        $display("FAIL fault_hold k=%0d got=%b exp=%b", k, obs(), ev(1'b0, 1'b1, 1'b0, 2'b01));
      end
    end
    set_lamps(1'b1, 1'b0, 1'b1);
    step();
    set_lamps(1'b1, 1'b0, 1'b0);
    n_tests++;
    if (obs() !== ev(1'b0, 1'b1, 1'b1, 2'b00)) begin
      n_fail++;
      $display("FAIL fault_set got=%b exp=%b", obs(), ev(1'b0, 1'b1, 1'b1, 2'b00));
    end
    for (int k = 1; k <= 20; k++) begin
      step();
      n_tests++;
      if (obs() !== ev(1'b0, 1'b1, 1'b1, 2'b00)) begin
        n_fail++;
        $display("FAIL fault_sticky k=%0d got=%b exp=%b", k, obs(), ev(1'b0, 1'b1, 1'b1, 2'b00));
      end
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if (obs() !== 5'b0) begin
      n_fail++;
      $display("FAIL fault_reset got=%b exp=%b", obs(), 5'b0);
    end
    step();
    reset = 1'b1;
    set_lamps(1'b0, 1'b0, 1'b0);
    step();
    set_lamps(1'b1, 1'b0, 1'b0);
    n_tests++;
    if (obs() !== ev(1'b0, 1'b0, 1'b1, 2'b00)) begin
      n_fail++;
      $display("FAIL fault_dark got=%b exp=%b", obs(), ev(1'b0, 1'b0, 1'b1, 2'b00));
    end
    #2 reset = 1'b0;
    step();
    reset = 1'b1;
    park();
  endtask

  task automatic test_auto();
    logic [4:0] exp;
    int last;
`ifdef AUTO_CYCLE_EN
    last = AP + 10;
`else
    last = 200;
`endif
    bus.btn    = 1'b0;
    bus.sensor = 1'b0;
    set_lamps(1'b1, 1'b0, 1'b0);
    #2 reset = 1'b0;
    step();
    reset = 1'b1;
    for (int k = 1; k <= last; k++) begin
      step();
`ifdef AUTO_CYCLE_EN
      if (k < AP)           exp = ev(1'b0, 1'b0, 1'b0, 2'b00);
      else if (k == AP)     exp = ev(1'b0, 1'b1, 1'b0, 2'b00);
      else if (k == AP + 1) exp = ev(1'b0, 1'b1, 1'b0, 2'b01);
      else                  exp = ev(1'b1, 1'b1, 1'b0, 2'b10);
`else
      exp = ev(1'b0, 1'b0, 1'b0, 2'b00);
`endif
      n_tests++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL auto k=%0d got=%b exp=%b", k, obs(), exp);
      end
    end
  endtask

  initial begin
    bus.btn    = 1'b0;
    bus.sensor = 1'b0;
    set_lamps(1'b1, 1'b0, 1'b0);
    test_reset();
    park();
    test_glitch();
    test_nominal();
    test_latched_green();
    test_fault();
    test_auto();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_request_ctrl.md
Name: traffic_request_ctrl

Overview:
- Upstream request stage for the traffic-light FSM. It generates that FSM's `start` input from a pedestrian pushbutton and a vehicle-loop sensor.
- Both raw inputs are synchronised and debounced, and requests are latched.
- `start` is issued only after red has been held for a minimum time. It is then held until the light FSM acknowledges by showing green.
- The block also watches the light FSM's R/Y/G outputs and flags illegal lamp combinations.

Parameters:
- DEBOUNCE, 4: consecutive stable synchronised cycles required before a debounced level changes.
- MIN_RED, 8: minimum continuous cycles of R=1 before `start` may assert.
- CNT_W, 8: width of the internal counters; must hold max(DEBOUNCE, MIN_RED, AUTO_PERIOD).
- AUTO_PERIOD, 64: idle red cycles before an automatic request. Used only with AUTO_CYCLE_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous reset, active-low; 0 clears all state.
- btn  in  1  raw pedestrian pushbutton, asynchronous.
- sensor  in  1  raw vehicle-loop detector, asynchronous.
- R  in  1  red lamp from light FSM.
- Y  in  1  yellow lamp from light FSM.
- G  in  1  green lamp from light FSM.
- start  out  1  request to light FSM, registered.
- req_pending  out  1  a request is latched and not yet serviced.
- fault  out  1  sticky illegal-lamp flag.
- state_o  out  2  current FSM state, for debug.

Behaviour:
- Reset (reset=0, async): start=0, req_pending=0, fault=0, state_o=IDLE(00). Synchronisers, debounced levels, red_cnt, debounce counters and auto counter all clear to 0. Reset mid-operation aborts immediately; no request survives.
- Input conditioning:
  - btn and sensor each pass through a 2-FF synchroniser and then an identical debouncer.
  - Debounced level changes when the synchronised value has differed from it for DEBOUNCE consecutive cycles. Any return to the old value clears the stability counter.
  - A rising edge of either debounced level is a one-cycle req_evt. Simultaneous edges count as a single req_evt.
  - Latency: req_pending rises DEBOUNCE+3 edges after btn rises (+1 for async sampling). A pulse shorter than DEBOUNCE synchronised cycles produces nothing.
- red_cnt: increments while R=1 and saturates at MIN_RED; cleared in any cycle with R=0.
- Legal lamp vector: exactly one of R, Y, G is high.
  - Illegal vector (none or more than one high) for one sampled cycle sets fault=1 the next cycle. fault clears only on reset.
  - While fault=1: FSM forced to IDLE, start held 0. req_pending is kept and still settable.
- req_pending:
  - Set by req_evt in IDLE, HOLD or SERVE.
  - req_evt during ISSUE is absorbed.
  - Cleared on the ISSUE→SERVE transition.
- FSM, state_o encoding in brackets:
  - IDLE (00), start=0: to HOLD when req_pending=1 and R=1.
  - HOLD (01), start=0: to ISSUE when red_cnt==MIN_RED; back to IDLE if R=0.
  - ISSUE (10), start=1: to SERVE on the first cycle G=1; start deasserts the following cycle. There is no timeout: start is held indefinitely while G=0.
  - SERVE (11), start=0: to IDLE when R=1; red_cnt restarts from 0 on that red.
- Boundary cases:
  - A request arriving during G or Y is latched. It is serviced only after the light returns to red and MIN_RED red cycles have elapsed.
  - Holding btn continuously yields one request per debounced rising edge, not repeated requests.

Optional Feature:
- Macro: AUTO_CYCLE_EN.
- Defined:
  - A counter runs while the FSM is in IDLE with R=1 and req_pending=0.
  - It is cleared on any other condition, on req_evt, and on reset.
  - On reaching AUTO_PERIOD it forces req_pending=1 and clears itself, giving a periodic light cycle with no demand.
- Undefined: no counter logic is synthesised; the block idles in red indefinitely without a request.

Test Plan:
- Reset: reset=0 with btn=1, R=1 → start=0, req_pending=0, fault=0, state_o=00. No change through 20 cycles.
- Glitch reject: R=1 steady; btn high for 2 cycles, then low → req_pending stays 0 and start stays 0 for 30 cycles.
- Nominal: R=1 from cycle 0; btn rises at cycle 12 and is held 10 cycles.
  - req_pending=1 at cycle 19±1, state_o=01, then start=1 (state_o=10).
  - Drive R=0, G=1 → start=0 and req_pending=0 one cycle later, state_o=11.
  - Restore R=1 → state_o=00.
- Latched-during-green: G=1; press sensor → req_pending=1, start=0. Y for 5 cycles, then R=1 → start asserts at edge MIN_RED+1 after R rises.
- Fault: R=1 and G=1 together for 1 cycle mid-HOLD → fault=1 next cycle, state_o=00, start=0. fault stays 1 after lamps return legal, until reset.
- AUTO_CYCLE_EN built: R=1, no inputs → req_pending=1 after 64 idle cycles, then start after the HOLD check. Build without the macro → no start within 200 cycles.
